// File: rtl/march_bist_ctrl.sv
// March C- BIST sequencer: drives a single-port RAM through the six March
// elements, checks every read, and reports pass/fail plus first-failure info.
module march_bist_ctrl #(
  parameter int unsigned size   = 6,
  parameter int unsigned length = 8,
  parameter int unsigned errw   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [length-1:0] bg,
  output logic              mem_cs,
  output logic              mem_rwbar,
  output logic [size-1:0]   mem_addr,
  output logic [length-1:0] mem_wdata,
  input  logic [length-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [size-1:0]   fail_addr,
  output logic [2:0]        fail_elem,
  output logic [length-1:0] fail_exp,
  output logic [length-1:0] fail_act,
  output logic [errw-1:0]   err_count
);

  localparam logic [2:0] last_elem = 3'd5;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state;
  logic [length-1:0] bg_q;
  logic [length-1:0] cur_exp;   // expected data of the op on the bus
  logic [2:0]        elem_q;    // element of the op on the bus
  logic [size-1:0]   addr_q;    // address of the op on the bus
  logic              op_q;      // 0 = first op at this address, 1 = second

  logic              last_op;
  logic              last_addr;
  logic              dir_down;
  logic              run_end;
  logic [2:0]        nxt_elem;
  logic [size-1:0]   nxt_addr;
  logic              nxt_op;
  logic              nxt_rd;
  logic [length-1:0] nxt_data;
  logic              rd_miss;

  // Elements 1..4 are read-then-write; element 0 is write only, element 5 read only.
  function automatic logic op_is_read(input logic [2:0] e, input logic o);
    return (e == last_elem) || ((e != 3'd0) && !o);
  endfunction

  // True when the op's data is D1 (inverted background).
  function automatic logic op_is_inv(input logic [2:0] e, input logic o);
    if (op_is_read(e, o))
      return (e == 3'd2) || (e == 3'd4);
    else
      return (e == 3'd1) || (e == 3'd3);
  endfunction

  function automatic logic elem_down(input logic [2:0] e);
    return (e == 3'd3) || (e == 3'd4);
  endfunction

  // Step from the op on the bus to the next op of the March sequence.
  always_comb begin
    nxt_elem  = elem_q;
    nxt_addr  = addr_q;
    nxt_op    = op_q;
    run_end   = 1'b0;
    dir_down  = elem_down(elem_q);
    last_op   = ((elem_q == 3'd0) || (elem_q == last_elem)) ? 1'b1 : op_q;
    last_addr = dir_down ? (addr_q == '0) : (addr_q == '1);
    if (!last_op) begin
      nxt_op = 1'b1;
    end else if (!last_addr) begin
      nxt_op   = 1'b0;
      nxt_addr = dir_down ? (addr_q - size'(1)) : (addr_q + size'(1));
    end else if (elem_q == last_elem) begin
      run_end = 1'b1;
    end else begin
      nxt_op   = 1'b0;
      nxt_elem = 3'(elem_q + 3'd1);
      nxt_addr = elem_down(nxt_elem) ? '1 : '0;
    end
    nxt_rd   = op_is_read(nxt_elem, nxt_op);
    nxt_data = op_is_inv(nxt_elem, nxt_op) ? ~bg_q : bg_q;
  end

  // Read check for the op ending at this edge.
  always_comb begin
    rd_miss = (state == RUN) && mem_cs && mem_rwbar && (mem_rdata != cur_exp);
  end

  // Control FSM with registered RAM interface and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      bg_q      <= '0;
      cur_exp   <= '0;
      elem_q    <= '0;
      addr_q    <= '0;
      op_q      <= 1'b0;
      mem_cs    <= 1'b0;
      mem_rwbar <= 1'b1;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      fail      <= 1'b0;
      fail_addr <= '0;
      fail_elem <= '0;
      fail_exp  <= '0;
      fail_act  <= '0;
      err_count <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state     <= RUN;
            bg_q      <= bg;
            cur_exp   <= bg;
            elem_q    <= '0;
            addr_q    <= '0;
            op_q      <= 1'b0;
            mem_cs    <= 1'b1;
            mem_rwbar <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= bg;
            busy      <= 1'b1;
            done      <= 1'b0;
            fail      <= 1'b0;
            fail_addr <= '0;
            fail_elem <= '0;
            fail_exp  <= '0;
            fail_act  <= '0;
            err_count <= '0;
          end
        end
        RUN: begin
          if (rd_miss) begin
            if (err_count != '1)
              err_count <= err_count + errw'(1);
            if (!fail) begin
              fail      <= 1'b1;
              fail_addr <= addr_q;
              fail_elem <= elem_q;
              fail_exp  <= cur_exp;
              fail_act  <= mem_rdata;
            end
          end
          if (run_end) begin
            state     <= DONE;
            mem_cs    <= 1'b0;
            mem_rwbar <= 1'b1;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
            done      <= 1'b1;
          end else begin
            elem_q    <= nxt_elem;
            addr_q    <= nxt_addr;
            op_q      <= nxt_op;
            cur_exp   <= nxt_data;
            mem_addr  <= nxt_addr;
            mem_rwbar <= nxt_rd;
            mem_wdata <= nxt_rd ? '0 : nxt_data;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_march_bist_ctrl.sv
// Self-checking bench for march_bist_ctrl: a RAM model with injectable faults
// and a reference March C- op list built from the algorithm definition.
module tb_march_bist_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] bg;
  logic       mem_cs, mem_rwbar;
  logic [5:0] mem_addr;
  logic [7:0] mem_wdata, mem_rdata;
  logic       busy, done, fail;
  logic [5:0] fail_addr;
  logic [2:0] fail_elem;
  logic [7:0] fail_exp, fail_act, err_count;

  int total = 0;
  int bad   = 0;

  march_bist_ctrl #(.size(6), .length(8), .errw(8)) dut (
    .clk(clk), .rst(rst), .start(start), .bg(bg),
    .mem_cs(mem_cs), .mem_rwbar(mem_rwbar), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .done(done), .fail(fail), .fail_addr(fail_addr),
    .fail_elem(fail_elem), .fail_exp(fail_exp), .fail_act(fail_act),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  // Fault controls
  logic       flt_en  = 1'b0;
  logic       flt_inv = 1'b0;
  logic [5:0] flt_addr = '0;
  int         flt_bit = 0;
  logic       flt_val = 1'b0;

  function automatic logic [7:0] faulty(input logic [5:0] a, input logic [7:0] v);
    logic [7:0] r;
    r = flt_inv ? ~v : v;
    if (flt_en && a == flt_addr) r[flt_bit] = flt_val;
    return r;
  endfunction

  // RAM model
  logic [7:0] ram [64];
  always @(posedge clk) if (mem_cs && !mem_rwbar) ram[mem_addr] <= mem_wdata;
  always_comb mem_rdata = (mem_cs && mem_rwbar) ? faulty(mem_addr, ram[mem_addr]) : 8'h00;

  // Reference model
  typedef struct {
    logic       rd;
    logic [5:0] addr;
    logic [7:0] data;
    logic [2:0] elem;
  } op_t;
  op_t exp_q[$];
  logic [7:0] m_bg;
  logic       m_fail;
  logic [5:0] m_addr;
  logic [2:0] m_elem;
  logic [7:0] m_exp, m_act;
  int         m_err;

  function automatic void add_elem(input logic dn, input int e,
                                   input logic has_r, input logic rinv,
                                   input logic has_w, input logic winv);
    op_t o;
    for (int k = 0; k < 64; k++) begin
      o.addr = dn ? 6'(63 - k) : 6'(k);
      o.elem = 3'(e);
      if (has_r) begin o.rd = 1'b1; o.data = rinv ? ~m_bg : m_bg; exp_q.push_back(o); end
      if (has_w) begin o.rd = 1'b0; o.data = winv ? ~m_bg : m_bg; exp_q.push_back(o); end
    end
  endfunction

  function automatic void build_model(input logic [7:0] bgv);
    logic [7:0] mm [64];
    logic [7:0] act;
    m_bg = bgv;
    exp_q.delete();
    add_elem(1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0); // M0 up   w D0
    add_elem(1'b0, 1, 1'b1, 1'b0, 1'b1, 1'b1); // M1 up   r D0 w D1
    add_elem(1'b0, 2, 1'b1, 1'b1, 1'b1, 1'b0); // M2 up   r D1 w D0
    add_elem(1'b1, 3, 1'b1, 1'b0, 1'b1, 1'b1); // M3 down r D0 w D1
    add_elem(1'b1, 4, 1'b1, 1'b1, 1'b1, 1'b0); // M4 down r D1 w D0
    add_elem(1'b0, 5, 1'b1, 1'b0, 1'b0, 1'b0); // M5 up   r D0
    m_fail = 1'b0; m_addr = '0; m_elem = '0; m_exp = '0; m_act = '0; m_err = 0;
    for (int i = 0; i < 64; i++) mm[i] = 8'h00;
    foreach (exp_q[i]) begin
      if (!exp_q[i].rd) mm[exp_q[i].addr] = exp_q[i].data;
      else begin
        act = faulty(exp_q[i].addr, mm[exp_q[i].addr]);
        if (act != exp_q[i].data) begin
          if (m_err < 255) m_err++;
          if (!m_fail) begin
            m_fail = 1'b1; m_addr = exp_q[i].addr; m_elem = exp_q[i].elem;
            m_exp = exp_q[i].data; m_act = act;
          end
        end
      end
    end
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    total++;
    assert (got === expv) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, got, expv);
    end
  endtask

  // One full run; start is pulsed again at op index pulse_at (-1 = never).
  task automatic run(input logic [7:0] bgv, input int pulse_at);
    int nrd, nwr;
    op_t o;
    nrd = 0; nwr = 0;
    build_model(bgv);
    @(negedge clk);
    check("pre_start_busy", 32'(busy), 32'd0);
    bg = bgv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; bg = 8'($urandom);
    check("start_clear", {done, fail, err_count}, 32'd0);
    for (int i = 0; i < 640; i++) begin
      o = exp_q[i];
      check($sformatf("op%0d", i), {busy, mem_cs, mem_rwbar, mem_addr, mem_wdata},
            {1'b1, 1'b1, o.rd, o.addr, (o.rd ? 8'h00 : o.data)});
      if (mem_cs && mem_rwbar) nrd++;
      if (mem_cs && !mem_rwbar) nwr++;
      if (i == pulse_at) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    check("end_bus", {busy, done, mem_cs, mem_rwbar, mem_addr}, {1'b0, 1'b1, 1'b0, 1'b1, 6'd0});
    check("reads", nrd, 320);
    check("writes", nwr, 320);
    check("fail", 32'(fail), 32'(m_fail));
    check("fail_addr", 32'(fail_addr), 32'(m_addr));
    check("fail_elem", 32'(fail_elem), 32'(m_elem));
    check("fail_exp", 32'(fail_exp), 32'(m_exp));
    check("fail_act", 32'(fail_act), 32'(m_act));
    check("err_count", 32'(err_count), 32'(m_err));
    repeat (3) @(posedge clk);
    #1;
    check("done_hold", {busy, done, mem_cs, err_count}, {1'b0, 1'b1, 1'b0, 8'(m_err)});
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; bg = 8'h00;
    #2;
    check("rst_ctl", {busy, done, fail, mem_cs, mem_rwbar, mem_addr, mem_wdata},
          {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6'd0, 8'd0});
    check("rst_res", {fail_addr, fail_elem, fail_exp, fail_act}, 32'd0);
    check("rst_err", 32'(err_count), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;

    run(8'h00, -1);
    check("clean_fail", 32'(fail), 32'd0);
    run(8'h55, -1);

    flt_en = 1'b1; flt_addr = 6'd5; flt_bit = 0; flt_val = 1'b1;
    run(8'h00, -1);
    check("sa1_addr", 32'(fail_addr), 32'd5);
    check("sa1_elem", 32'(fail_elem), 32'd1);
    check("sa1_act", {fail_exp, fail_act}, {8'h00, 8'h01});
    check("sa1_cnt", 32'(err_count), 32'd3);

    flt_addr = 6'd63; flt_bit = 7; flt_val = 1'b0;
    run(8'hFF, -1);
    check("sa0_elem", {fail_elem, fail_addr}, {3'd1, 6'd63});
    check("sa0_act", {fail_exp, fail_act}, {8'hFF, 8'h7F});
    check("sa0_cnt", 32'(err_count), 32'd3);

    flt_en = 1'b0;
    run(8'($urandom), 100);
    run(8'($urandom), -1);

    flt_en = 1'b1; flt_addr = 6'($urandom); flt_bit = int'($urandom_range(7, 0));
    flt_val = 1'($urandom);
    run(8'($urandom), -1);

    flt_en = 1'b0; flt_inv = 1'b1;
    run(8'($urandom), -1);
    check("sat", 32'(err_count), 32'hFF);

    // Reset in the middle of a run
    @(negedge clk); bg = 8'($urandom); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (300) @(posedge clk);
    #3; rst = 1'b1; #1;
    check("mid_rst", {mem_cs, busy, fail, err_count}, 32'd0);
    @(posedge clk); #1;
    check("mid_rst_hold", {mem_cs, mem_rwbar, busy, done}, {1'b0, 1'b1, 1'b0, 1'b0});
    @(negedge clk); rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("idle_after", {mem_cs, busy, done, fail}, 32'd0);
    flt_inv = 1'b0;
    run(8'($urandom), -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/march_bist_ctrl.md
Name: march_bist_ctrl

Overview:
- Sequencer for the MBIST path: runs a March C- test over a single-port RAM (depth 2**size, width length) and checks every read.
- Owns the RAM chip-select, read/write, address and write-data lines while busy; normal-mode muxing stays in the top level.
- Reports pass/fail, the first failing location and a saturating error count.

Parameters:
size, 6, address width; RAM depth = 2**size
length, 8, data width
errw, 8, width of the error counter

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
start  input  1  single-cycle request to begin a test run
bg  input  length  data background, sampled at start
mem_cs  output  1  RAM chip select
mem_rwbar  output  1  1 = read, 0 = write
mem_addr  output  size  RAM address
mem_wdata  output  length  RAM write data
mem_rdata  input  length  RAM read data, combinational from mem_addr when mem_cs=1 and mem_rwbar=1
busy  output  1  test in progress
done  output  1  run complete; held until next accepted start
fail  output  1  sticky, at least one read mismatch in this run
fail_addr  output  size  address of first mismatch
fail_elem  output  3  March element (0-5) of first mismatch
fail_exp  output  length  expected data of first mismatch
fail_act  output  length  read data of first mismatch
err_count  output  errw  number of mismatching reads, saturating at all-ones

Behaviour:
- Reset (async, any state): state IDLE, all outputs 0 (mem_rwbar=1, mem_cs=0), fail_* cleared, err_count=0.
- FSM states: IDLE, RUN, DONE.
  - IDLE or DONE with start=1 at a rising edge: latch bg, clear done/fail/fail_*/err_count, go to RUN with element 0, address 0, op 0.
  - In RUN, start is ignored.
- Data values: D0 = latched bg; D1 = ~bg.
- March C- sequence, one RAM operation per cycle, all memory outputs registered:
  - M0 up (w D0)
  - M1 up (r D0, w D1)
  - M2 up (r D1, w D0)
  - M3 down (r D0, w D1)
  - M4 down (r D1, w D0)
  - M5 up (r D0)
- Address ordering: "up" runs 0 to 2**size-1; "down" runs 2**size-1 to 0. Within an element, all ops for one address finish before the address steps.
- Element transitions: the last address of an element is followed directly by the first op of the next element; no idle cycle.
- Total operations = 10 * 2**size (640 for size=6).
- Op cycle timing:
  - Op i is presented on the mem_* outputs during the cycle following edge k+i, where k is the start-accept edge.
  - Writes have mem_cs=1, mem_rwbar=0, mem_wdata=value.
  - Reads have mem_cs=1, mem_rwbar=1, mem_wdata=0.
- Read check: mem_rdata is compared at the rising edge ending the read cycle. On mismatch:
  - err_count increments, saturating.
  - If fail was 0, capture fail_addr/elem/exp/act and set fail=1 in the same edge.
- Completion: at edge k+640 (last op done), busy=0, done=1, mem_cs=0, mem_rwbar=1, mem_addr=0. Go to DONE; fail_* and err_count are held.
- busy=1 exactly for cycles k+1 through k+640 inclusive.
- Address wrap: address counters never wrap inside an element. The terminal address (all-ones up, 0 down) ends the element.
- A mismatch on the final read (M5, top address) is still counted and captured before done rises.
- Reset mid-run aborts immediately, with no further RAM access.

Test Plan:
- Fault-free RAM, size=6, bg=0x00, start pulse at edge k: busy high cycles k+1..k+640; done=1 after edge k+640; fail=0, err_count=0; exactly 320 writes and 320 reads observed.
- bg=0x55, fault-free: M0 writes 0x55 to addresses 0..63 ascending; first M1 write drives 0xAA to address 0; M3 starts at address 63; done with fail=0.
- RAM bit0 stuck-at-1 at address 5, bg=0x00: fail=1, fail_addr=5, fail_elem=1, fail_exp=0x00, fail_act=0x01, err_count=3.
- Stuck fault at address 63 bit7 stuck-at-0, bg=0xFF: first mismatch in M1 (expects 0xFF, reads 0x7F); err_count=3; the final M5 read at address 63 is counted before done.
- start pulsed at cycle 100 of a run: ignored, total length unchanged. start again in DONE: done drops, counters clear, new run of 640 ops.
- rst asserted at cycle 300 of a run, between edges: mem_cs=0, busy=0, fail=0, err_count=0 immediately; IDLE after release; a fresh start yields a full 640-op run.
